// File: rtl/game_flow_ctrl.sv
// Game-level screen sequencer: START -> GAME -> PLAYER_1/PLAYER_2 -> START, with a clear pulse when a round begins.
// Optional pause toggle compiled in with GAME_FLOW_PAUSE_EN.
module game_flow_ctrl #(
  parameter int unsigned WIN_POINTS      = 10,
  parameter int unsigned WIN_HOLD_FRAMES = 300,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       vblnk,
  input  logic [4:0] points_p1,
  input  logic [4:0] points_p2,
  output logic [1:0] screen,
  output logic       game_clr,
  output logic       round_active,
  output logic       paused
);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_GAME  = 2'b01,
    ST_P1    = 2'b10,
    ST_P2    = 2'b11
  } state_t;

  localparam int unsigned     CNT_W     = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [4:0]      WIN_P     = 5'(WIN_POINTS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WIN_HOLD_FRAMES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_btn_q;
  logic                   r_start_pulse;
  logic                   r_vblnk_q;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_frame_cnt;
  logic [CNT_W-1:0]       w_frame_cnt_nxt;
  logic                   r_game_clr;
  logic                   w_game_clr_nxt;
  logic                   r_paused;
  logic                   w_paused_nxt;
  logic                   r_round_active;
  logic                   w_round_active_nxt;
  logic                   w_start_rise;
  logic                   w_frame_tick;
  logic                   w_p1_win;
  logic                   w_p2_win;

  assign w_start_rise = r_sync[SYNC_STAGES-1] & ~r_btn_q;
  assign w_frame_tick = vblnk & ~r_vblnk_q;
  assign w_p1_win     = (points_p1 >= WIN_P);
  assign w_p2_win     = (points_p2 >= WIN_P);

  // Button synchronizer and edge detector; the pulse is registered so it is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync        <= '0;
      r_btn_q       <= 1'b0;
      r_start_pulse <= 1'b0;
      r_vblnk_q     <= 1'b0;
    end else begin
      r_sync        <= {r_sync[SYNC_STAGES-2:0], btn_start};
      r_btn_q       <= r_sync[SYNC_STAGES-1];
      r_start_pulse <= w_start_rise;
      r_vblnk_q     <= vblnk;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_START;
      r_frame_cnt    <= '0;
      r_game_clr     <= 1'b0;
      r_paused       <= 1'b0;
      r_round_active <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_frame_cnt    <= w_frame_cnt_nxt;
      r_game_clr     <= w_game_clr_nxt;
      r_paused       <= w_paused_nxt;
      r_round_active <= w_round_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = '0;
    w_game_clr_nxt  = 1'b0;
    w_paused_nxt    = 1'b0;
    case (r_state)
      ST_START: begin
        if (r_start_pulse) begin
          w_state_nxt    = ST_GAME;
          w_game_clr_nxt = 1'b1;
        end
      end
      ST_GAME: begin
`ifdef GAME_FLOW_PAUSE_EN
        w_paused_nxt = r_paused;
        if (r_start_pulse) begin
          w_paused_nxt = ~r_paused;
        end else if (!r_paused) begin
          if (w_p1_win)      w_state_nxt = ST_P1;
          else if (w_p2_win) w_state_nxt = ST_P2;
        end
`else
        // Player 1 is checked first so a simultaneous win goes to player 1.
        if (w_p1_win)      w_state_nxt = ST_P1;
        else if (w_p2_win) w_state_nxt = ST_P2;
`endif
      end
      ST_P1, ST_P2: begin
        w_frame_cnt_nxt = r_frame_cnt;
        if (r_start_pulse) begin
          w_state_nxt     = ST_START;
          w_frame_cnt_nxt = '0;
        end else if (w_frame_tick) begin
          if (r_frame_cnt == HOLD_LAST) begin
            w_state_nxt     = ST_START;
            w_frame_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_START;
    endcase
    w_round_active_nxt = (w_state_nxt == ST_GAME) && !w_paused_nxt;
  end

  assign screen       = r_state;
  assign game_clr     = r_game_clr;
  assign round_active = r_round_active;
  assign paused       = r_paused;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short winner hold so frame timing is quick to exercise.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       vblnk;
  logic [4:0] points_p1;
  logic [4:0] points_p2;
  logic [1:0] screen;
  logic       game_clr;
  logic       round_active;
  logic       paused;

  int checks = 0;
  int errors = 0;
  int clr_seen;

  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_GAME  = 2'b01;
  localparam logic [1:0] S_P1    = 2'b10;
  localparam logic [1:0] S_P2    = 2'b11;

  game_flow_ctrl #(
    .WIN_POINTS      (10),
    .WIN_HOLD_FRAMES (3),
    .SYNC_STAGES     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btn_start),
    .vblnk        (vblnk),
    .points_p1    (points_p1),
    .points_p2    (points_p2),
    .screen       (screen),
    .game_clr     (game_clr),
    .round_active (round_active),
    .paused       (paused)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press and hold: pulse lands after 3 edges, the state/outputs change on the 4th.
  task automatic press(input string tag, input logic [1:0] exp_scr, input logic exp_clr);
    btn_start = 1'b1;
    repeat (3) tick();
    chk({tag, "_clr_early"}, {7'd0, game_clr}, 8'd0);
    tick();
    chk({tag, "_screen"}, {6'd0, screen}, {6'd0, exp_scr});
    chk({tag, "_clr"}, {7'd0, game_clr}, {7'd0, exp_clr});
    btn_start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic vtick();
    vblnk = 1'b1;
    tick();
    vblnk = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; btn_start = 1'b0; vblnk = 1'b0; points_p1 = 5'd0; points_p2 = 5'd0;
    repeat (3) tick();
    chk("rst_screen", {6'd0, screen}, {6'd0, S_START});
    chk("rst_clr", {7'd0, game_clr}, 8'd0);
    chk("rst_active", {7'd0, round_active}, 8'd0);
    chk("rst_paused", {7'd0, paused}, 8'd0);
    rst = 1'b1;
    tick();

    // First press held for 1000 cycles: one transition, one clear pulse.
    btn_start = 1'b1;
    repeat (3) tick();
    chk("start_3cyc_screen", {6'd0, screen}, {6'd0, S_START});
    tick();
    chk("start_4cyc_screen", {6'd0, screen}, {6'd0, S_GAME});
    chk("start_clr", {7'd0, game_clr}, 8'd1);
    chk("start_active", {7'd0, round_active}, 8'd1);
    tick();
    chk("start_clr_one", {7'd0, game_clr}, 8'd0);
    clr_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (game_clr) clr_seen++;
    end
    chk("hold_no_second_clr", 8'(clr_seen), 8'd0);
    chk("hold_screen", {6'd0, screen}, {6'd0, S_GAME});
    btn_start = 1'b0;
    repeat (3) tick();

    // Player 2 ramps to 10 with player 1 on 3.
    points_p1 = 5'd3;
    for (int p = 0; p < 10; p++) begin
      points_p2 = 5'(p);
      tick();
    end
    chk("p2_ramp_game", {6'd0, screen}, {6'd0, S_GAME});
    points_p2 = 5'd10;
    tick();
    chk("p2_win_screen", {6'd0, screen}, {6'd0, S_P2});
    chk("p2_win_active", {7'd0, round_active}, 8'd0);

    press("p2_exit", S_START, 1'b0);

    // Simultaneous win goes to player 1.
    points_p1 = 5'd9; points_p2 = 5'd9;
    press("tie_start", S_GAME, 1'b1);
    chk("tie_9_game", {6'd0, screen}, {6'd0, S_GAME});
    points_p1 = 5'd10; points_p2 = 5'd10;
    tick();
    chk("tie_screen", {6'd0, screen}, {6'd0, S_P1});

    // Hold of 3 frames: leave on the third vblnk rising edge.
    vtick();
    chk("hold_f1", {6'd0, screen}, {6'd0, S_P1});
    vtick();
    chk("hold_f2", {6'd0, screen}, {6'd0, S_P1});
    vblnk = 1'b1;
    tick();
    chk("hold_f3_screen", {6'd0, screen}, {6'd0, S_START});
    chk("hold_f3_clr", {7'd0, game_clr}, 8'd0);
    vblnk = 1'b0;
    tick();

    // Re-enter (p1 still 10 so player 1 wins again), then abort the hold with a press.
    press("rewin_start", S_GAME, 1'b1);
    chk("rewin_screen", {6'd0, screen}, {6'd0, S_P1});
    vtick();
    press("hold_abort", S_START, 1'b0);

    // Asynchronous reset in the middle of a round.
    points_p1 = 5'd0; points_p2 = 5'd0;
    press("arst_start", S_GAME, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("arst_screen", {6'd0, screen}, {6'd0, S_START});
    chk("arst_paused", {7'd0, paused}, 8'd0);
    chk("arst_active", {7'd0, round_active}, 8'd0);
    #2 rst = 1'b1;
    tick();
    chk("arst_no_clr", {7'd0, game_clr}, 8'd0);
    press("arst_restart", S_GAME, 1'b1);
    chk("arst_restart_active", {7'd0, round_active}, 8'd1);

`ifdef GAME_FLOW_PAUSE_EN
    press("pause_on", S_GAME, 1'b0);
    chk("pause_on_flag", {7'd0, paused}, 8'd1);
    chk("pause_on_active", {7'd0, round_active}, 8'd0);
    points_p1 = 5'd10;
    repeat (3) tick();
    chk("pause_hold_screen", {6'd0, screen}, {6'd0, S_GAME});
    btn_start = 1'b1;
    repeat (4) tick();
    chk("pause_off_flag", {7'd0, paused}, 8'd0);
    chk("pause_off_screen", {6'd0, screen}, {6'd0, S_GAME});
    tick();
    chk("pause_win_screen", {6'd0, screen}, {6'd0, S_P1});
    chk("pause_win_paused", {7'd0, paused}, 8'd0);
    btn_start = 1'b0;
    repeat (3) tick();
`else
    press("nopause_press", S_GAME, 1'b0);
    chk("nopause_flag", {7'd0, paused}, 8'd0);
    chk("nopause_active", {7'd0, round_active}, 8'd1);
    points_p1 = 5'd10;
    tick();
    chk("nopause_win", {6'd0, screen}, {6'd0, S_P1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-level state machine that produces the 2-bit `screen` code consumed by the VGA screen multiplexer.
- Takes the start button and both players' point counters, and decides which screen is shown: START, GAME, PLAYER_1 or PLAYER_2.
- Issues a one-cycle clear pulse to the game drawing logic when a round begins.
- Times the winner screen in video frames, counted from the vga_tim blanking signal.

Parameters:
- WIN_POINTS, 10, point count at which a player wins (must be <= 31).
- WIN_HOLD_FRAMES, 300, frames the winner screen is held before returning to START (5 s at 60 Hz, must be >= 1).
- SYNC_STAGES, 2, flip-flop stages in the btn_start synchronizer (must be >= 2).

Ports:
- clk  in  1  pixel clock, the same clock as the VGA pipeline.
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start button, asynchronous to clk, active-high.
- vblnk  in  1  vertical blank from vga_tim; its rising edge is the frame tick.
- points_p1  in  5  player 1 score, unsigned.
- points_p2  in  5  player 2 score, unsigned.
- screen  out  2  screen code from vga_pkg: START=2'b00, GAME=2'b01, PLAYER_1=2'b10, PLAYER_2=2'b11.
- game_clr  out  1  one-cycle pulse that clears scores and positions in draw_game.
- round_active  out  1  high while screen==GAME and the game is not paused.
- paused  out  1  pause flag; tied 0 unless PAUSE_EN is defined.

Behaviour:
- Reset values, applied asynchronously while rst=0:
  - screen=START, game_clr=0, round_active=0, paused=0.
  - Synchronizer, edge registers and frame counter are cleared.
  - Leaving reset is synchronous with the next clk edge.
- Start input path:
  - btn_start passes through SYNC_STAGES flip-flops, then a rising-edge detector.
  - start_pulse goes high for one cycle, SYNC_STAGES+1 cycles after btn_start rises.
  - Holding the button produces exactly one pulse.
- Frame tick:
  - vblnk is registered once; frame_tick = vblnk & ~vblnk_q.
  - frame_tick is one cycle wide, once per frame.
- All outputs are registered. screen changes in the cycle after the triggering condition is sampled.
- State START:
  - start_pulse -> GAME; game_clr=1 for exactly that one transition cycle.
  - Score inputs are ignored in START.
- State GAME:
  - points_p1 >= WIN_POINTS -> PLAYER_1.
  - Else points_p2 >= WIN_POINTS -> PLAYER_2.
  - If both players reach WIN_POINTS in the same cycle, PLAYER_1 wins.
  - start_pulse is ignored in GAME (see PAUSE_EN).
- States PLAYER_1 / PLAYER_2:
  - Frame counter, width $clog2(WIN_HOLD_FRAMES+1), is zeroed on entry.
  - Counter increments on each frame_tick.
  - When frame_tick arrives with counter == WIN_HOLD_FRAMES-1 -> START.
  - start_pulse -> START immediately, whichever comes first.
  - If start_pulse and the final frame_tick coincide: single transition to START, no game_clr.
- game_clr is asserted only on the START->GAME transition, never elsewhere.
- Scores are compared unsigned at 5 bits; there is no wrap handling, and draw_game saturates at 31.
- Illegal state encodings recover to START on the next clk edge.
- Reset mid-round forces START; game_clr is not emitted by reset.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- Defined:
  - In GAME, start_pulse toggles paused.
  - While paused=1: win comparisons are suppressed, round_active=0, screen stays GAME.
  - paused clears on any exit from GAME and on reset.
- Undefined:
  - paused is a constant 0 and start_pulse is ignored in GAME.
  - round_active = (screen==GAME).

Test Plan:
- Reset then btn_start 0->1 held for 1000 cycles -> screen START->GAME exactly SYNC_STAGES+2 cycles after the edge; game_clr high for exactly 1 cycle; no second pulse.
- In GAME, points_p2 ramps to 10 while points_p1=3 -> screen=PLAYER_2 the next cycle; round_active=0.
- In GAME, points_p1 and points_p2 both step 9->10 in the same cycle -> screen=PLAYER_1.
- In PLAYER_1, WIN_HOLD_FRAMES=3, vblnk toggling -> START on the 3rd vblnk rising edge, and not earlier; a button press mid-hold -> START immediately with game_clr=0.
- rst asserted low mid-GAME, asynchronous to clk -> screen=START and paused=0 without waiting for a clk edge; after release, one button press -> GAME with game_clr pulse.
- GAME_FLOW_PAUSE_EN defined: press in GAME -> paused=1; points_p1=10 applied -> screen stays GAME; second press -> paused=0, then PLAYER_1 the next cycle.
